icache: RTL
===========

# icache

Direct-mapped instruction cache: the responding end of the instruction-fetch request interface, sitting between `iFetch` and the memory controller. It accepts one PC per request and returns the 32-bit instruction word: in one cycle on a hit, or after a word fill from the memory controller on a miss. On pipeline clear it discards any in-flight response.

## Interface

Parameters:
- `INDEX_WIDTH`, default 6: line-index bits, giving 2^INDEX_WIDTH one-word lines.

Ports:
- `clk` input 1: clock. One clock domain only.
- `rst` input 1: reset, asynchronous, active-high.
- `rdy` input 1: global enable. When 0, the whole block holds all state.
- `clr` input 1: pipeline clear (branch mispredict or exception).
- `if_valid` input 1: fetch request from `iFetch`.
- `if_pc` input 32: requested PC. Bits [1:0] are ignored.
- `ic_ready` output 1: cache can accept a request this cycle.
- `ic_valid` output 1: one-cycle response pulse.
- `ic_inst` output 32: instruction word, valid while `ic_valid`=1.
- `ic_pc` output 32: PC of the returned instruction.
- `mem_req` output 1: word read request to the memory controller.
- `mem_addr` output 32: word-aligned read address.
- `mem_done` input 1: memory controller has the read data this cycle.
- `mem_data` input 32: read data, valid while `mem_done`=1.

## Operation

- Address split:
  - tag = `if_pc[31:INDEX_WIDTH+2]`
  - index = `if_pc[INDEX_WIDTH+1:2]`
- Storage: per line, a valid bit, a tag and a 32-bit data word. Only the valid bits are reset.
- States:
  - IDLE: `ic_ready`=1.
  - MISS: `mem_req`=1, `ic_ready`=0.
  - DRAIN: `mem_req`=0, `ic_ready`=0.
- A request is accepted when `rdy`=1, `if_valid`=1, `ic_ready`=1 and `clr`=0.
- Accept and hit:
  - Next edge: `ic_valid`=1, `ic_inst`=line data, `ic_pc`=`if_pc`.
  - State stays IDLE.
- Accept and miss:
  - Latch the PC.
  - `mem_addr`={pc[31:2],2'b00}.
  - Go to MISS.
- MISS with `mem_done`=1:
  - Write the line: valid=1, tag, data.
  - Next edge: `ic_valid`=1, `ic_inst`=`mem_data`, `ic_pc`=the latched PC.
  - Go to IDLE.
- `clr`=1:
  - `ic_valid` is 0 on the following cycle.
  - In IDLE: any simultaneous request is ignored.
  - In MISS without `mem_done`: go to DRAIN.
  - In MISS with `mem_done`: fill the line, emit no response, go to IDLE.
- DRAIN: wait for `mem_done`, fill the line, emit no response, return to IDLE. The filled data is correct, so it is kept.
- `clr` never invalidates lines. Self-modifying code is unsupported.
- `rdy`=0: all registers hold, nothing is accepted or filled, and `mem_done` is ignored. The memory controller is frozen by the same `rdy`.
- Reset values:
  - `ic_valid`=0, `ic_inst`=0, `ic_pc`=0.
  - `mem_req`=0, `mem_addr`=0.
  - State IDLE, all valid bits 0.
- Reset mid-miss: the request is abandoned. The memory controller is reset by the same `rst`.

## Timing

- Hit latency: 1 cycle from acceptance to `ic_valid`.
- Miss latency: the `mem_done` edge plus 1 cycle.
- `mem_req` and `mem_addr` are registered and stay stable from the MISS entry edge until the edge that samples `mem_done`=1.
- `mem_req` drops on that same edge.
- `ic_ready` is a combinational decode of the state register: 1 only in IDLE.
- Back-to-back hits give one response per cycle.
- A request is never accepted in the same cycle as a fill completion, because `ic_ready` is still 0 in that cycle.
- `ic_valid` is never high for two consecutive cycles on the same request.

## Configuration

- `ICACHE_EN` defined:
  - Tag, data and valid arrays are present.
  - Hits are served as described above.
- `ICACHE_EN` undefined:
  - No arrays are built, and every request is treated as a miss.
  - Fills are not stored.
  - The MISS/DRAIN/`clr` behaviour and response timing are unchanged.
  - Interface and parameters are identical.

## Test plan

- Cold miss: after reset, request `if_pc`=0x00000010.
  - Expect `mem_req`=1 with `mem_addr`=0x10.
  - Return `mem_done` with `mem_data`=0x00500093.
  - Expect one `ic_valid` pulse with `ic_inst`=0x00500093 and `ic_pc`=0x10.
- Hit: repeat the request for 0x10.
  - Expect `ic_valid` one cycle later with the same data.
  - Expect `mem_req` to stay 0.
  - Without `ICACHE_EN`, a miss is required instead.
- Conflict: with INDEX_WIDTH=6, request 0x110 (same index as 0x10, different tag).
  - Expect a miss with `mem_addr`=0x110.
  - A following request for 0x10 must miss again.
- Clear during miss: assert `clr` while in MISS, then deliver `mem_done` 3 cycles later.
  - Expect no `ic_valid`.
  - Expect `ic_ready` to return to 1.
  - A later request for that PC must hit.
- Stall: drop `rdy` for 4 cycles while in MISS, with `mem_done` pulsed during the stall.
  - Expect no fill and outputs held.
  - Completion occurs only after `rdy`=1.
- Reset mid-miss: assert `rst` while in MISS.
  - Expect `mem_req`=0 and `ic_valid`=0 immediately.
  - Expect all lines invalid: a request for 0x10 must miss.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between iFetch and the
// memory controller. Hits respond one cycle after acceptance; misses issue a
// registered word read and respond one cycle after mem_done.
// Optional feature macro: ICACHE_EN. When defined, the valid/tag/data arrays
// are built and hits are served. When undefined, every request misses and
// fills are discarded. The ports and timing are the same in both builds.
module icache #(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        ic_ready,
  output logic        ic_valid,
  output logic [31:0] ic_inst,
  output logic [31:0] ic_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ic_valid_q, ic_valid_d;
  logic [31:0] ic_inst_q, ic_inst_d;
  logic [31:0] ic_pc_q, ic_pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] pc_q, pc_d;

  logic        hit;
  logic [31:0] hit_data;

`ifdef ICACHE_EN
  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = 30 - INDEX_WIDTH;

  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [LINES];
  logic [31:0]            data_q [LINES];
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]       req_tag, fill_tag;
  logic                   fill_we;

  assign req_idx  = if_pc[INDEX_WIDTH+1:2];
  assign req_tag  = if_pc[31:INDEX_WIDTH+2];
  assign fill_idx = pc_q[INDEX_WIDTH+1:2];
  assign fill_tag = pc_q[31:INDEX_WIDTH+2];
  // A fill completes in MISS or DRAIN regardless of clr; the data is correct.
  assign fill_we  = rdy && mem_done && (state_q == S_MISS || state_q == S_DRAIN);
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_data = data_q[req_idx];

  // Valid bits: set by fills, never cleared except by reset.
  always_comb begin
    valid_d = valid_q;
    if (fill_we) valid_d[fill_idx] = 1'b1;
  end

  // Valid-bit register; the only part of the arrays that is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data storage, written on fill only.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign ic_ready = (state_q == S_IDLE);
  assign ic_valid = ic_valid_q;
  assign ic_inst  = ic_inst_q;
  assign ic_pc    = ic_pc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Next-state and response logic; rdy=0 freezes everything.
  always_comb begin
    state_d    = state_q;
    ic_valid_d = ic_valid_q;
    ic_inst_d  = ic_inst_q;
    ic_pc_d    = ic_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_d       = pc_q;
    if (rdy) begin
      ic_valid_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (if_valid && !clr) begin
            if (hit) begin
              ic_valid_d = 1'b1;
              ic_inst_d  = hit_data;
              ic_pc_d    = if_pc;
            end else begin
              pc_d       = if_pc;
              mem_req_d  = 1'b1;
              mem_addr_d = {if_pc[31:2], 2'b00};
              state_d    = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
            if (!clr) begin
              ic_valid_d = 1'b1;
              ic_inst_d  = mem_data;
              ic_pc_d    = pc_q;
            end
          end else if (clr) begin
            mem_req_d = 1'b0;
            state_d   = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_done) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ic_valid_q <= 1'b0;
      ic_inst_q  <= '0;
      ic_pc_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      ic_valid_q <= ic_valid_d;
      ic_inst_q  <= ic_inst_d;
      ic_pc_q    <= ic_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_q       <= pc_d;
    end
  end

endmodule
